// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-loads an instruction array from a byte stream, then serves core fetches
module inst_rom_loader #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_ce_i,
  input  logic [31:0]   rom_addr_i,
  output logic [DW-1:0] rom_data_o,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  output logic          ld_ready_o,
  input  logic          ld_restart_i,
  output logic          boot_done_o,
  output logic          err_o,
  output logic [AW:0]   words_loaded_o
);
  localparam logic [31:0] DEPTH   = 32'(1) << AW;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  typedef enum logic [1:0] {LEN, DATA, DONE} state_t;
  state_t         state, state_nx;
  logic [1:0]     bcnt;
  logic [23:0]    sh;
  logic [31:0]    cnt, widx, word;
  logic           acc, last, we;
  logic           unused_addr;
  logic [DW-1:0]  mem [2**AW];
  assign acc         = ld_valid_i & ld_ready_o;
  assign last        = acc & (bcnt == 2'd3);
  assign word        = {sh, ld_data_i};
  assign unused_addr = ^rom_addr_i[1:0];
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LEN;
    else      state <= state_nx;
  // next state: restart wins, otherwise advance on the last byte of a group
  always_comb begin
    state_nx = state;
    if (ld_restart_i)                                        state_nx = LEN;
    else if (last && state == LEN)                           state_nx = (word == '0) ? DONE : DATA;
    else if (last && state == DATA && widx + 32'd1 == cnt)   state_nx = DONE;
  end
  // byte assembly, count/word counters, sticky error and registered ready
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bcnt       <= '0;
      sh         <= '0;
      cnt        <= '0;
      widx       <= '0;
      err_o      <= 1'b0;
      ld_ready_o <= 1'b0;
    end else begin
      ld_ready_o <= state_nx != DONE;
      if (ld_restart_i) begin
        bcnt  <= '0;
        widx  <= '0;
        err_o <= 1'b0;
      end else if (acc) begin
        bcnt <= bcnt + 2'd1;
        sh   <= {sh[15:0], ld_data_i};
        if (last && state == LEN) begin
          cnt   <= word;
          err_o <= word > DEPTH;
        end
        if (last && state == DATA) widx <= widx + 32'd1;
      end
    end
  // instruction array write port; contents survive reset and restart
  always_ff @(posedge clk)
    if (we) mem[widx[AW-1:0]] <= word;
  // outputs: done flag, saturated word count, write enable and gated fetch
  always_comb begin
    boot_done_o    = state == DONE;
    words_loaded_o = (widx >= DEPTH) ? DEPTH_W : widx[AW:0];
    we             = last && state == DATA && !ld_restart_i && widx < DEPTH;
    rom_data_o     = (rom_ce_i && state == DONE && rom_addr_i[31:AW+2] == '0) ? mem[rom_addr_i[AW+1:2]] : '0;
  end
endmodule
